// File: rtl/uart_tx_port_pkg.sv
// Shared constants and types for the UART transmit port.
package uart_tx_pkg;

  // Byte offsets within the port's 16-byte block
  localparam logic [3:0] REG_THR_DLL = 4'h0;
  localparam logic [3:0] REG_DLM     = 4'h2;
  localparam logic [3:0] REG_LCR     = 4'h6;
  localparam logic [3:0] REG_LSR     = 4'hA;

  // Line status bit positions
  localparam int unsigned LSR_THRE_BIT = 5;
  localparam int unsigned LSR_TEMT_BIT = 6;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_port_if.sv
// Byte-lane register bus between the serial IO decoder and the UART port.
interface uart_tx_port_if;
  logic       Enable_H;
  logic [3:0] Address;
  logic       WE_L;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  modport master (output Enable_H, Address, WE_L, DataIn, input DataOut);
  modport slave  (input Enable_H, Address, WE_L, DataIn, output DataOut);
endinterface

// File: rtl/uart_tx_port_fifo.sv
// 4x8 synchronous transmit FIFO with count-based full/empty.
module tx_fifo
  import uart_tx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped even when a pop happens alongside it.
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_port.sv
// UART transmit port: register file, baud generator and 8N1 framing FSM.
module uart_tx_port
  import uart_tx_pkg::*;
(
  input  logic          Clock,
  input  logic          Reset_H,
  uart_tx_port_if.slave bus,
  output logic          TxD
);

  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);

  logic        wr_cond, wr_cond_q, wr_stb;
  logic [7:0]  dll_q, dlm_q;
  logic        dlab_q;
  logic [15:0] div_eff;
  tx_state_e   state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [3:0]  os_cnt_q, os_cnt_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [15:0] div_act_q, div_act_d;
  logic        div_last, bit_end;
  logic        txd_q, txd_d;
  logic        push, pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_empty;
  logic        thre, temt;
  logic [7:0]  lsr, rd_data;

  assign wr_cond = bus.Enable_H && !bus.WE_L && !bus.Address[0];
  assign wr_stb  = wr_cond && !wr_cond_q;
  assign push    = wr_stb && (bus.Address == REG_THR_DLL) && !dlab_q;
  assign div_eff = ({dlm_q, dll_q} == 16'd0) ? 16'd1 : {dlm_q, dll_q};

  assign thre = fifo_empty;
  assign temt = fifo_empty && (state_q == ST_IDLE);

  // Write-strobe edge detector and programmable registers
  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      wr_cond_q <= 1'b0;
      dll_q     <= 8'h01;
      dlm_q     <= 8'h00;
      dlab_q    <= 1'b0;
    end else begin
      wr_cond_q <= wr_cond;
      if (wr_stb) begin
        case (bus.Address)
          REG_THR_DLL: if (dlab_q) dll_q <= bus.DataIn;
          REG_DLM:     if (dlab_q) dlm_q <= bus.DataIn;
          REG_LCR:     dlab_q <= bus.DataIn[7];
          default:     ;
        endcase
      end
    end
  end

  tx_fifo u_fifo (
    .clk_i   (Clock),
    .rst_i   (Reset_H),
    .push_i  (push),
    .wdata_i (bus.DataIn),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty)
  );

  // The divisor is sampled into div_act at each bit start, so a new
  // divisor only takes effect at the following bit boundary.
  assign div_last = (div_cnt_q == div_act_q - 16'd1);
  assign bit_end  = div_last && (os_cnt_q == OS_LAST);

  // Framing FSM next-state, baud counters and serial output value
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    os_cnt_d  = os_cnt_q;
    div_cnt_d = div_cnt_q;
    div_act_d = div_act_q;
    pop       = 1'b0;
    txd_d     = 1'b1;

    if (state_q != ST_IDLE) begin
      if (div_last) begin
        div_cnt_d = '0;
        os_cnt_d  = os_cnt_q + 4'd1;
      end else begin
        div_cnt_d = div_cnt_q + 16'd1;
      end
      if (bit_end) div_act_d = div_eff;
    end

    case (state_q)
      ST_IDLE: begin
        txd_d     = 1'b1;
        os_cnt_d  = '0;
        div_cnt_d = '0;
        div_act_d = div_eff;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_rdata;
          state_d = ST_START;
        end
      end
      ST_START: begin
        txd_d = 1'b0;
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        txd_d = shreg_q[0];
        if (bit_end) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          bit_idx_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_rdata;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Framing FSM state, counters and registered serial output
  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      os_cnt_q  <= '0;
      div_cnt_q <= '0;
      div_act_q <= 16'd1;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      os_cnt_q  <= os_cnt_d;
      div_cnt_q <= div_cnt_d;
      div_act_q <= div_act_d;
      txd_q     <= txd_d;
    end
  end

  assign TxD = txd_q;

  // Read data mux; idle bus reads zero
  always_comb begin
    lsr               = '0;
    lsr[LSR_TEMT_BIT] = temt;
    lsr[LSR_THRE_BIT] = thre;
    rd_data           = 8'h00;
    if (bus.Enable_H) begin
      case (bus.Address)
        REG_THR_DLL: rd_data = dlab_q ? dll_q : 8'h00;
        REG_DLM:     rd_data = dlab_q ? dlm_q : 8'h00;
        REG_LCR:     rd_data = {dlab_q, 7'b0000011};
        REG_LSR:     rd_data = lsr;
        default:     rd_data = 8'h00;
      endcase
    end
  end

  assign bus.DataOut = rd_data;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed self-checking bench for uart_tx_port.
module tb_uart_tx_port;

  logic Clock = 1'b0;
  logic Reset_H;
  logic TxD;
  int   total = 0;
  int   bad   = 0;

  uart_tx_port_if bus();

  uart_tx_port dut (
    .Clock   (Clock),
    .Reset_H (Reset_H),
    .bus     (bus),
    .TxD     (TxD)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    bus.Enable_H = 1'b0;
    bus.WE_L     = 1'b1;
    bus.Address  = 4'h0;
    bus.DataIn   = 8'h00;
  endtask

  // Called at a negedge; strobe is seen by exactly one rising edge.
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d, input logic en);
    bus.Enable_H = en;
    bus.WE_L     = 1'b0;
    bus.Address  = a;
    bus.DataIn   = d;
    @(negedge Clock);
    bus.Enable_H = 1'b0;
    bus.WE_L     = 1'b1;
  endtask

  // Register write followed by one idle clock so the next strobe is a new cycle.
  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    bus_write(a, d, 1'b1);
    @(negedge Clock);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    bus.Enable_H = 1'b1;
    bus.WE_L     = 1'b1;
    bus.Address  = a;
    #1;
    d = bus.DataOut;
    bus.Enable_H = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_H = 1'b1;
    @(negedge Clock);
    Reset_H = 1'b0;
  endtask

  // Collects one 10-bit frame starting at the current negedge: bits[i] is the
  // first sample of bit i, stable[i] says every sample of that bit matched it.
  task automatic sample_frame(input int d, input logic do_lsr,
                              output logic [9:0] bits, output logic [9:0] stable,
                              output logic [7:0] lsr);
    logic first;
    lsr = 8'hxx;
    for (int i = 0; i < 10; i++) begin
      first     = TxD;
      stable[i] = 1'b1;
      for (int k = 0; k < 16 * d; k++) begin
        if (TxD !== first) stable[i] = 1'b0;
        if (do_lsr && i == 4 && k == 8) bus_read(4'hA, lsr);
        @(negedge Clock);
      end
      bits[i] = first;
    end
  endtask

  task automatic test_reset();
    logic [7:0] r;
    do_reset();
    total++;
    if (TxD !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", TxD); end
    bus_read(4'hA, r);
    total++;
    if (r !== 8'h60) begin bad++; $display("FAIL reset_lsr got=%h exp=60", r); end
    bus_read(4'h6, r);
    total++;
    if (r !== 8'h03) begin bad++; $display("FAIL reset_lcr got=%h exp=03", r); end
    bus.Address = 4'hA;
    #1;
    total++;
    if (bus.DataOut !== 8'h00) begin bad++; $display("FAIL disabled_read got=%h exp=00", bus.DataOut); end
    wr_reg(4'h6, 8'h80);
    bus_read(4'h0, r);
    total++;
    if (r !== 8'h01) begin bad++; $display("FAIL reset_dll got=%h exp=01", r); end
    bus_read(4'h2, r);
    total++;
    if (r !== 8'h00) begin bad++; $display("FAIL reset_dlm got=%h exp=00", r); end
    wr_reg(4'h6, 8'h00);
  endtask

  task automatic test_basic_frame();
    logic [9:0] b, s;
    logic [7:0] l, r;
    do_reset();
    bus_write(4'h0, 8'h55, 1'b1);
    @(negedge Clock);
    total++;
    if (TxD !== 1'b1) begin bad++; $display("FAIL basic_latency_n1 got=%b exp=1", TxD); end
    @(negedge Clock);
    sample_frame(1, 1'b0, b, s, l);
    total++;
    if (b !== 10'b1_01010101_0) begin bad++; $display("FAIL basic_bits got=%b exp=%b", b, 10'b1010101010); end
    total++;
    if (s !== 10'h3FF) begin bad++; $display("FAIL basic_bit_len got=%b exp=%b", s, 10'h3FF); end
    bus_read(4'hA, r);
    total++;
    if (r !== 8'h60) begin bad++; $display("FAIL basic_lsr_after got=%h exp=60", r); end
  endtask

  task automatic test_divisor();
    logic [9:0] b, s;
    logic [7:0] l, r;
    do_reset();
    wr_reg(4'h6, 8'h80);
    wr_reg(4'h0, 8'h03);
    wr_reg(4'h2, 8'h00);
    bus_read(4'h0, r);
    total++;
    if (r !== 8'h03) begin bad++; $display("FAIL div_dll_rb got=%h exp=03", r); end
    bus_read(4'h6, r);
    total++;
    if (r !== 8'h83) begin bad++; $display("FAIL div_lcr_rb got=%h exp=83", r); end
    wr_reg(4'h6, 8'h00);
    bus_write(4'h0, 8'hA5, 1'b1);
    bus_read(4'hA, r);
    total++;
    if (r !== 8'h00) begin bad++; $display("FAIL div_lsr_queued got=%h exp=00", r); end
    @(negedge Clock);
    @(negedge Clock);
    sample_frame(3, 1'b1, b, s, l);
    total++;
    if (b !== 10'b1_10100101_0) begin bad++; $display("FAIL div_bits got=%b exp=%b", b, 10'b1101001010); end
    total++;
    if (s !== 10'h3FF) begin bad++; $display("FAIL div_bit_len48 got=%b exp=%b", s, 10'h3FF); end
    total++;
    if (l !== 8'h20) begin bad++; $display("FAIL div_lsr_mid got=%h exp=20", l); end
    bus_read(4'hA, r);
    total++;
    if (r !== 8'h60) begin bad++; $display("FAIL div_lsr_after got=%h exp=60", r); end
  endtask

  task automatic test_div_zero();
    logic [9:0] b, s;
    logic [7:0] l;
    do_reset();
    wr_reg(4'h6, 8'h80);
    wr_reg(4'h0, 8'h00);
    wr_reg(4'h6, 8'h00);
    bus_write(4'h0, 8'h81, 1'b1);
    @(negedge Clock);
    @(negedge Clock);
    sample_frame(1, 1'b0, b, s, l);
    total++;
    if (b !== 10'b1_10000001_0) begin bad++; $display("FAIL divzero_bits got=%b exp=%b", b, 10'b1100000010); end
    total++;
    if (s !== 10'h3FF) begin bad++; $display("FAIL divzero_bit_len got=%b exp=%b", s, 10'h3FF); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] data [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [9:0] fb [5];
    logic [9:0] fs [5];
    logic [7:0] fl [5];
    logic [7:0] r;
    logic [9:0] e;
    logic       saw_low;
    do_reset();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bus_write(4'h0, data[i], 1'b1);
          if (i < 5) @(negedge Clock);
        end
        bus_read(4'hA, r);
        total++;
        if (r !== 8'h00) begin bad++; $display("FAIL b2b_lsr_full got=%h exp=00", r); end
      end
      begin
        repeat (3) @(negedge Clock);
        for (int f = 0; f < 5; f++)
          sample_frame(1, (f == 1 || f == 4), fb[f], fs[f], fl[f]);
      end
    join
    for (int f = 0; f < 5; f++) begin
      e = {1'b1, data[f], 1'b0};
      total++;
      if (fb[f] !== e || fs[f] !== 10'h3FF) begin
        bad++;
        $display("FAIL b2b_frame%0d got=%b stable=%b exp=%b", f + 1, fb[f], fs[f], e);
      end
    end
    total++;
    if (fl[1] !== 8'h00) begin bad++; $display("FAIL b2b_thre_busy got=%h exp=00", fl[1]); end
    total++;
    if (fl[4] !== 8'h20) begin bad++; $display("FAIL b2b_thre_last got=%h exp=20", fl[4]); end
    saw_low = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (TxD !== 1'b1) saw_low = 1'b1;
      @(negedge Clock);
    end
    total++;
    if (saw_low !== 1'b0) begin bad++; $display("FAIL b2b_byte6_dropped got=%b exp=0", saw_low); end
    bus_read(4'hA, r);
    total++;
    if (r !== 8'h60) begin bad++; $display("FAIL b2b_lsr_after got=%h exp=60", r); end
  endtask

  task automatic test_held_strobe();
    logic [9:0] b, s;
    logic [7:0] l, r;
    logic       saw_low;
    do_reset();
    fork
      begin
        bus.Enable_H = 1'b1;
        bus.WE_L     = 1'b0;
        bus.Address  = 4'h0;
        bus.DataIn   = 8'h3C;
        repeat (10) @(negedge Clock);
        bus_idle();
      end
      begin
        repeat (3) @(negedge Clock);
        sample_frame(1, 1'b0, b, s, l);
      end
    join
    total++;
    if (b !== 10'b1_00111100_0 || s !== 10'h3FF) begin
      bad++;
      $display("FAIL held_frame got=%b stable=%b exp=%b", b, s, 10'b1001111000);
    end
    saw_low = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (TxD !== 1'b1) saw_low = 1'b1;
      @(negedge Clock);
    end
    total++;
    if (saw_low !== 1'b0) begin bad++; $display("FAIL held_single got=%b exp=0", saw_low); end
    bus_read(4'hA, r);
    total++;
    if (r !== 8'h60) begin bad++; $display("FAIL held_lsr got=%h exp=60", r); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] r;
    logic       saw_low;
    do_reset();
    bus_write(4'h0, 8'hF0, 1'b1);
    repeat (2) @(negedge Clock);
    repeat (16 + 3 * 16 + 8) @(negedge Clock);
    total++;
    if (TxD !== 1'b0) begin bad++; $display("FAIL mid_bit3 got=%b exp=0", TxD); end
    Reset_H = 1'b1;
    @(negedge Clock);
    Reset_H = 1'b0;
    total++;
    if (TxD !== 1'b1) begin bad++; $display("FAIL mid_txd_after_rst got=%b exp=1", TxD); end
    saw_low = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (TxD !== 1'b1) saw_low = 1'b1;
      @(negedge Clock);
    end
    total++;
    if (saw_low !== 1'b0) begin bad++; $display("FAIL mid_no_residual got=%b exp=0", saw_low); end
    bus_read(4'hA, r);
    total++;
    if (r !== 8'h60) begin bad++; $display("FAIL mid_lsr got=%h exp=60", r); end
    wr_reg(4'h6, 8'h80);
    bus_read(4'h0, r);
    total++;
    if (r !== 8'h01) begin bad++; $display("FAIL mid_dll got=%h exp=01", r); end
    wr_reg(4'h6, 8'h00);
  endtask

  task automatic test_ignored_writes();
    logic [7:0] r;
    logic       saw_low;
    do_reset();
    bus_write(4'h0, 8'h77, 1'b0); @(negedge Clock);
    bus_write(4'h6, 8'h80, 1'b0); @(negedge Clock);
    bus_write(4'h1, 8'h99, 1'b1); @(negedge Clock);
    bus_write(4'hB, 8'h55, 1'b1); @(negedge Clock);
    bus_write(4'h7, 8'h80, 1'b1); @(negedge Clock);
    bus_write(4'h2, 8'h12, 1'b1); @(negedge Clock);
    saw_low = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (TxD !== 1'b1) saw_low = 1'b1;
      @(negedge Clock);
    end
    total++;
    if (saw_low !== 1'b0) begin bad++; $display("FAIL ign_txd_idle got=%b exp=0", saw_low); end
    bus_read(4'hA, r);
    total++;
    if (r !== 8'h60) begin bad++; $display("FAIL ign_lsr got=%h exp=60", r); end
    bus_read(4'h6, r);
    total++;
    if (r !== 8'h03) begin bad++; $display("FAIL ign_lcr got=%h exp=03", r); end
    wr_reg(4'h6, 8'h80);
    bus_read(4'h2, r);
    total++;
    if (r !== 8'h00) begin bad++; $display("FAIL ign_dlm got=%h exp=00", r); end
    bus_read(4'h0, r);
    total++;
    if (r !== 8'h01) begin bad++; $display("FAIL ign_dll got=%h exp=01", r); end
    wr_reg(4'h6, 8'h00);
  endtask

  initial begin
    Reset_H = 1'b1;
    bus_idle();
    repeat (2) @(negedge Clock);
    test_reset();
    test_basic_frame();
    test_divisor();
    test_div_zero();
    test_back_to_back();
    test_held_strobe();
    test_reset_midframe();
    test_ignored_writes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
